// File: rtl/key_event.sv
// Turns a debounced key level into clean one-cycle short, long and repeat events.
// A key held through reset is ignored until it has been released once.
module key_event #(
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20,
    parameter bit REPEAT_EN    = 1'b1,
    parameter int CNT_W        = 8
) (
    input  logic clk100hz,
    input  logic rst_n,
    input  logic key_in,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic key_pressed
);

    typedef enum logic [1:0] {
        WAIT_REL,
        IDLE,
        PRESS,
        LONG
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_act;
    logic             w_short;
    logic             w_long;
    logic             w_rep;
    logic             r_short;
    logic             r_long;
    logic             r_rep;
    logic             r_pressed;

    assign w_act = key_in ^ ACTIVE_LOW;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_short     = 1'b0;
        w_long      = 1'b0;
        w_rep       = 1'b0;
        unique case (r_state)
            WAIT_REL: begin
                if (!w_act) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            IDLE: begin
                // The first active sample counts as sample 1 of the press.
                if (w_act) begin
                    if (LONG_TICKS == 1) begin
                        w_state_nxt = LONG;
                        w_cnt_nxt   = '0;
                        w_long      = 1'b1;
                    end else begin
                        w_state_nxt = PRESS;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            PRESS: begin
                if (!w_act) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_short     = 1'b1;
                end else if (r_cnt == LONG_LAST) begin
                    w_state_nxt = LONG;
                    w_cnt_nxt   = '0;
                    w_long      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            LONG: begin
                if (!w_act) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == REP_LAST) begin
                    w_cnt_nxt = '0;
                    w_rep     = REPEAT_EN;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = WAIT_REL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk100hz or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= WAIT_REL;
            r_cnt     <= '0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_rep     <= 1'b0;
            r_pressed <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_short   <= w_short;
            r_long    <= w_long;
            r_rep     <= w_rep;
            r_pressed <= (w_state_nxt == PRESS) || (w_state_nxt == LONG);
        end
    end

    assign short_pulse  = r_short;
    assign long_pulse   = r_long;
    assign repeat_pulse = r_rep;
    assign key_pressed  = r_pressed;

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event: vector table plus long-hold and reset sequences.
// Three instances: default, repeat disabled, and single-tick long press.
module tb_key_event;

    localparam logic P = 1'b0;
    localparam logic R = 1'b1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_in = R;

    logic s0, l0, r0, p0;
    logic s1, l1, r1, p1;
    logic s2, l2, r2, p2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_event u0 (
        .clk100hz(clk), .rst_n(rst_n), .key_in(key_in),
        .short_pulse(s0), .long_pulse(l0),
        .repeat_pulse(r0), .key_pressed(p0)
    );

    key_event #(.REPEAT_EN(1'b0)) u1 (
        .clk100hz(clk), .rst_n(rst_n), .key_in(key_in),
        .short_pulse(s1), .long_pulse(l1),
        .repeat_pulse(r1), .key_pressed(p1)
    );

    key_event #(.LONG_TICKS(1), .REPEAT_TICKS(2)) u2 (
        .clk100hz(clk), .rst_n(rst_n), .key_in(key_in),
        .short_pulse(s2), .long_pulse(l2),
        .repeat_pulse(r2), .key_pressed(p2)
    );

    typedef struct {
        logic       k;
        logic [3:0] e0;
        logic [3:0] e2;
    } vec_t;

    vec_t tv[17];

    task automatic chk(input string nm, input int a, input int e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
        end
    endtask

    task automatic step(input logic k);
        int n0, n1, n2;
        @(negedge clk);
        key_in = k;
        @(posedge clk);
        #1;
        n0 = int'(s0) + int'(l0) + int'(r0);
        n1 = int'(s1) + int'(l1) + int'(r1);
        n2 = int'(s2) + int'(l2) + int'(r2);
        chk("mutex", int'(n0 <= 1 && n1 <= 1 && n2 <= 1), 1);
    endtask

    int h_s0, h_l0, h_r0, h_lat, h_rfirst, h_rlast;
    int h_s1, h_l1, h_r1;

    task automatic hold(input int n);
        h_s0 = 0; h_l0 = 0; h_r0 = 0;
        h_lat = 0; h_rfirst = 0; h_rlast = 0;
        h_s1 = 0; h_l1 = 0; h_r1 = 0;
        for (int i = 1; i <= n + 1; i++) begin
            step((i <= n) ? P : R);
            h_s0 += int'(s0);
            h_s1 += int'(s1);
            h_l1 += int'(l1);
            h_r1 += int'(r1);
            if (l0) begin
                h_l0++;
                h_lat = i;
            end
            if (r0) begin
                h_r0++;
                if (h_rfirst == 0) h_rfirst = i;
                h_rlast = i;
            end
        end
    endtask

    task automatic reset_with(input logic k);
        key_in = k;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_u0", int'({s0, l0, r0, p0}), 0);
        chk("rst_u2", int'({s2, l2, r2, p2}), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int ps;
        tv[0]  = '{R, 4'b0000, 4'b0000};
        tv[1]  = '{P, 4'b0001, 4'b0101};
        tv[2]  = '{P, 4'b0001, 4'b0001};
        tv[3]  = '{P, 4'b0001, 4'b0011};
        tv[4]  = '{P, 4'b0001, 4'b0001};
        tv[5]  = '{P, 4'b0001, 4'b0011};
        tv[6]  = '{R, 4'b1000, 4'b0000};
        tv[7]  = '{R, 4'b0000, 4'b0000};
        tv[8]  = '{P, 4'b0001, 4'b0101};
        tv[9]  = '{P, 4'b0001, 4'b0001};
        tv[10] = '{P, 4'b0001, 4'b0011};
        tv[11] = '{R, 4'b1000, 4'b0000};
        tv[12] = '{P, 4'b0001, 4'b0101};
        tv[13] = '{P, 4'b0001, 4'b0001};
        tv[14] = '{P, 4'b0001, 4'b0011};
        tv[15] = '{R, 4'b1000, 4'b0000};
        tv[16] = '{R, 4'b0000, 4'b0000};

        reset_with(R);
        for (int i = 0; i < 17; i++) begin
            step(tv[i].k);
            chk($sformatf("vec%0d_u0", i), int'({s0, l0, r0, p0}), int'(tv[i].e0));
            chk($sformatf("vec%0d_u1", i), int'({s1, l1, r1, p1}), int'(tv[i].e0));
            chk($sformatf("vec%0d_u2", i), int'({s2, l2, r2, p2}), int'(tv[i].e2));
        end

        hold(99);
        chk("h99_short", h_s0, 1);
        chk("h99_long", h_l0, 0);
        chk("h99_rep", h_r0, 0);

        hold(100);
        chk("h100_long", h_l0, 1);
        chk("h100_lat", h_lat, 100);
        chk("h100_short", h_s0, 0);
        chk("h100_rep", h_r0, 0);

        hold(160);
        chk("h160_long", h_l0, 1);
        chk("h160_lat", h_lat, 100);
        chk("h160_rep", h_r0, 3);
        chk("h160_rfirst", h_rfirst, 120);
        chk("h160_rlast", h_rlast, 160);
        chk("h160_short", h_s0, 0);
        chk("h160_rep_dis", h_r1, 0);
        chk("h160_long_dis", h_l1, 1);
        chk("h160_short_dis", h_s1, 0);
        chk("h160_released", int'(p0), 0);

        reset_with(P);
        hold(50);
        chk("wr_short", h_s0, 0);
        chk("wr_long", h_l0, 0);
        chk("wr_rep", h_r0, 0);
        step(R);
        hold(3);
        chk("wr_next_short", h_s0, 1);
        chk("wr_next_long", h_l0, 0);

        ps = 0;
        for (int i = 1; i <= 60; i++) begin
            step(P);
            ps += int'(p0);
        end
        chk("r5_pressed_cnt", ps, 60);
        chk("r5_no_long", int'(l0), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r5_async_u0", int'({s0, l0, r0, p0}), 0);
        chk("r5_async_u2", int'({s2, l2, r2, p2}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        hold(5);
        chk("r5_after_short", h_s0, 0);
        chk("r5_after_long", h_l0, 0);
        chk("r5_after_rep", h_r0, 0);
        chk("r5_after_pressed", int'(p0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
